// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream (s_*), downstream (m_*), occupancy.
// flush is only present when PIPE_SKID_FLUSH_EN is defined.
interface pipe_skid_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic [1:0]       count;
`ifdef PIPE_SKID_FLUSH_EN
  logic             flush;
`endif

  // slave: the skid register itself
  modport slave (
    input  s_valid, s_data, m_ready,
`ifdef PIPE_SKID_FLUSH_EN
    input  flush,
`endif
    output s_ready, m_valid, m_data, count
  );

  // master: the environment driving/consuming the block
  modport master (
    output s_valid, s_data, m_ready,
`ifdef PIPE_SKID_FLUSH_EN
    output flush,
`endif
    input  s_ready, m_valid, m_data, count
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: main register drives m_data, skid catches one extra word.
// Optional PIPE_SKID_FLUSH_EN adds a flush input that empties the block.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  pipe_skid_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] main_q, main_nx;
  logic [WIDTH-1:0] skid_q, skid_nx;
  logic             accept, deliver, flush_i;

`ifdef PIPE_SKID_FLUSH_EN
  assign flush_i = bus.flush;
`else
  assign flush_i = 1'b0;
`endif

  // Handshakes qualified by state only, so no input reaches an output combinationally.
  assign accept  = bus.s_valid && (state != FULL);
  assign deliver = bus.m_ready && (state != EMPTY);

  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush_i) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nx = BUSY;
            main_nx  = bus.s_data;
          end
        end
        BUSY: begin
          if (accept && deliver) begin
            main_nx = bus.s_data;
          end else if (accept) begin
            state_nx = FULL;
            skid_nx  = bus.s_data;
          end else if (deliver) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            state_nx = BUSY;
            main_nx  = skid_q;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
    end
  end

  always_comb begin
    bus.s_ready = (state != FULL);
    bus.m_valid = (state != EMPTY);
    bus.m_data  = main_q;
    case (state)
      BUSY:    bus.count = 2'd1;
      FULL:    bus.count = 2'd2;
      default: bus.count = 2'd0;
    endcase
  end

endmodule
